// File: rtl/histogram_cdf.sv
// histogram_cdf
//   Builds the cumulative distribution function of one image tile for
//   histogram equalization and streams it, one bin per handshake, to the
//   equalization divider.
//
//   Flow: IDLE -> CLEAR (zero every bin) -> ACCUM (count SIZE pixels)
//         -> SCAN (emit running sum per bin) -> DONE (one-cycle pulse).
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low
//   start      request a new tile (honoured only in IDLE)
//   pix_in     pixel value
//   pix_valid  pix_in valid
//   pix_ready  pixel accepted this cycle (ACCUM only)
//   cdf_out    CDF value for bin cdf_bin
//   cdf_bin    bin index of cdf_out
//   cdf_last   cdf_valid on the final bin
//   cdf_valid  cdf_out/cdf_bin/cdf_last valid
//   cdf_ready  consumer accepts the current CDF value
//   cdf_min    CDF value of the lowest occupied bin
//   busy       not IDLE
//   done       one-cycle pulse after the last CDF handshake
module histogram_cdf #(
  parameter int PIX_W = 8,
  parameter int SIZE  = 64,
  parameter int CDF_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [CDF_W-1:0] cdf_out,
  output logic [PIX_W-1:0] cdf_bin,
  output logic             cdf_last,
  output logic             cdf_valid,
  input  logic             cdf_ready,
  output logic [CDF_W-1:0] cdf_min,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NBIN = 2 ** PIX_W;
  localparam logic [CDF_W-1:0] LAST_CNT = CDF_W'(SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_SCAN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // idx_q is the clear index in CLEAR and the scan index in SCAN.
  logic [PIX_W-1:0] idx_q,   idx_d;
  logic [CDF_W-1:0] cnt_q,   cnt_d;
  logic [CDF_W-1:0] acc_q,   acc_d;
  logic [PIX_W-1:0] pmin_q,  pmin_d;
  logic [CDF_W-1:0] cmin_q,  cmin_d;

  // Histogram contents are don't-care after reset: CLEAR precedes every tile.
  logic [CDF_W-1:0] hist_q [NBIN];

  logic             accept;
  logic             scanning;
  logic [PIX_W-1:0] min_next;
  logic [CDF_W-1:0] min_count;
  logic [CDF_W-1:0] scan_sum;

  assign accept   = (state_q == S_ACCUM) && pix_valid;
  assign scanning = (state_q == S_SCAN);
  assign min_next = (pix_in < pmin_q) ? pix_in : pmin_q;
  // cdf_min must include the final pixel's own increment, which has not
  // reached hist_q yet on the accepting edge.
  assign min_count = hist_q[min_next] +
                     ((pix_in == min_next) ? CDF_W'(1) : CDF_W'(0));
  assign scan_sum  = acc_q + hist_q[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pmin_d  = pmin_q;
    cmin_d  = cmin_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        idx_d  = idx_q + PIX_W'(1);
        cnt_d  = '0;
        acc_d  = '0;
        pmin_d = '1;
        if (idx_q == '1) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d  = cnt_q + CDF_W'(1);
          pmin_d = min_next;
          if (cnt_q == LAST_CNT) begin
            state_d = S_SCAN;
            idx_d   = '0;
            cmin_d  = min_count;
          end
        end
      end
      S_SCAN: begin
        if (cdf_ready) begin
          acc_d = scan_sum;
          idx_d = idx_q + PIX_W'(1);
          if (idx_q == '1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      pmin_q  <= '1;
      cmin_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pmin_q  <= pmin_d;
      cmin_q  <= cmin_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      hist_q[idx_q] <= '0;
    end else if (accept) begin
      hist_q[pix_in] <= hist_q[pix_in] + CDF_W'(1);
    end
  end

  // Outputs decode registered state only; gating with `scanning` makes them
  // read zero whenever reset forces IDLE.
  assign pix_ready = (state_q == S_ACCUM);
  assign cdf_valid = scanning;
  assign cdf_out   = scanning ? scan_sum : '0;
  assign cdf_bin   = scanning ? idx_q : '0;
  assign cdf_last  = scanning && (idx_q == '1);
  assign cdf_min   = cmin_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
